pc_gen: RTL and testbench

- Parametrised fetch-stage program-counter generator for the pipelined MIPS core.
- Produces the fetch address and its sequential successor, and applies stall, D-stage jump/branch redirects and exception redirects.
- Adds a pending-redirect buffer, so a redirect arriving during a stall is never lost.
- Sits at the front of IF, feeding instruction memory and the IF/ID register.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_gen_if.sv | 32 +++
 rtl/pc_next_sel.sv | 86 ++++++++
 rtl/pc_gen.sv | 69 ++++++
 tb/tb_pc_gen.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage PC generator.
package pc_pkg;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_EXC  = 3'd1,
        SRC_DRED = 3'd2,
        SRC_PEND = 3'd3,
        SRC_SEQ  = 3'd4
    } pc_src_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch control/address bundle between the pipeline and pc_gen.
// misalign_f exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              en;
    logic              redir_d_valid;
    logic [ADDR_W-1:0] redir_d_target;
    logic              exc_valid;
    logic [ADDR_W-1:0] pc_f;
    logic [ADDR_W-1:0] pc_step_f;
    logic              pend_valid;
`ifdef PC_ALIGN_CHECK_EN
    logic              misalign_f;
`endif

    modport master (
        output en, redir_d_valid, redir_d_target, exc_valid,
`ifdef PC_ALIGN_CHECK_EN
        input  misalign_f,
`endif
        input  pc_f, pc_step_f, pend_valid
    );

    modport slave (
        input  en, redir_d_valid, redir_d_target, exc_valid,
`ifdef PC_ALIGN_CHECK_EN
        output misalign_f,
`endif
        output pc_f, pc_step_f, pend_valid
    );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority select: exception > stall > live redirect > pending > sequential.
// With PC_ALIGN_CHECK_EN, misaligned redirect targets are replaced by the exception vector.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(DEF_EXC_VEC)
) (
    input  logic              en_i,
    input  logic              redir_valid_i,
    input  logic [ADDR_W-1:0] redir_target_i,
    input  logic              exc_valid_i,
    input  pc_state_e         state_i,
    input  logic [ADDR_W-1:0] pend_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] pc_step_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pend_o,
    output pc_state_e         state_o,
    output logic              misalign_o
);

    pc_src_e           src_s;
    logic [ADDR_W-1:0] load_s;

    // Priority encode the source of the next PC.
    always_comb begin
        src_s = SRC_NONE;
        if (exc_valid_i) begin
            src_s = SRC_EXC;
        end else if (!en_i) begin
            src_s = SRC_NONE;
        end else if (redir_valid_i) begin
            src_s = SRC_DRED;
        end else if (state_i == ST_HOLD) begin
            src_s = SRC_PEND;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // Build next PC, pending target and FSM state from the selected source.
    always_comb begin
        pc_o       = pc_i;
        pend_o     = pend_i;
        state_o    = state_i;
        misalign_o = 1'b0;
        load_s     = (src_s == SRC_DRED) ? redir_target_i : pend_i;
        case (src_s)
            SRC_EXC: begin
                pc_o    = EXC_VEC;
                state_o = ST_RUN;
            end
            SRC_NONE: begin
                if (redir_valid_i) begin
                    pend_o  = redir_target_i;
                    state_o = ST_HOLD;
                end else begin
                    state_o = state_i;
                end
            end
            SRC_DRED, SRC_PEND: begin
                state_o = ST_RUN;
`ifdef PC_ALIGN_CHECK_EN
                if (load_s[1:0] != 2'b00) begin
                    pc_o       = EXC_VEC;
                    misalign_o = 1'b1;
                end else begin
                    pc_o = load_s;
                end
`else
                pc_o = load_s;
`endif
            end
            SRC_SEQ: begin
                pc_o    = pc_step_i;
                state_o = ST_RUN;
            end
            default: begin
                pc_o    = EXC_VEC;
                state_o = ST_RUN;
            end
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: PC/PC+STEP registers, pending-redirect buffer and RUN/HOLD FSM.
// Optional misalignment trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int unsigned       STEP      = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);

    localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_step_q;
    logic [ADDR_W-1:0] pend_q, pend_d;
    pc_state_e         state_q, state_d;
    logic              misalign_q, misalign_d;

    pc_next_sel #(
        .ADDR_W  (ADDR_W),
        .EXC_VEC (EXC_VEC)
    ) u_next_sel (
        .en_i           (bus.en),
        .redir_valid_i  (bus.redir_d_valid),
        .redir_target_i (bus.redir_d_target),
        .exc_valid_i    (bus.exc_valid),
        .state_i        (state_q),
        .pend_i         (pend_q),
        .pc_i           (pc_q),
        .pc_step_i      (pc_step_q),
        .pc_o           (pc_d),
        .pend_o         (pend_d),
        .state_o        (state_d),
        .misalign_o     (misalign_d)
    );

    // pc_step is derived from the new PC so both registers always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            pc_step_q  <= RESET_VEC + STEP_W;
            pend_q     <= {ADDR_W{1'b0}};
            state_q    <= ST_RUN;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_step_q  <= pc_d + STEP_W;
            pend_q     <= pend_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc_f       = pc_q;
    assign bus.pc_step_f  = pc_step_q;
    assign bus.pend_valid = (state_q == ST_HOLD);
`ifdef PC_ALIGN_CHECK_EN
    assign bus.misalign_f = misalign_q;
`else
    logic unused_misalign_s;
    assign unused_misalign_s = misalign_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic against a
// rule-level reference model (PC value, optional single pending redirect).
`timescale 1ns/1ps
module tb_pc_gen;

    localparam logic [31:0] RST_VEC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    logic        m_mis;

    pc_gen_if #(.ADDR_W(32)) bus ();

    pc_gen #(
        .ADDR_W    (32),
        .RESET_VEC (RST_VEC),
        .EXC_VEC   (EXC_VEC),
        .STEP      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_target(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        if (t % 4 != 0) begin
            m_pc  = EXC_VEC;
            m_mis = 1'b1;
        end else begin
            m_pc = t;
        end
`else
        m_pc = t;
`endif
    endtask

    task automatic model_edge(input logic r, input logic e, input logic rv,
                              input logic [31:0] t, input logic x);
        m_mis = 1'b0;
        if (r) begin
            m_pc = RST_VEC;
            m_pend.delete();
        end else if (x) begin
            m_pc = EXC_VEC;
            m_pend.delete();
        end else if (!e) begin
            if (rv) begin
                m_pend.delete();
                m_pend.push_back(t);
            end
        end else if (rv) begin
            load_target(t);
            m_pend.delete();
        end else if (m_pend.size() != 0) begin
            load_target(m_pend[0]);
            m_pend.delete();
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc_f"}, bus.pc_f, m_pc);
        chk({tag, ".pc_step_f"}, bus.pc_step_f, m_pc + 32'd4);
        chk({tag, ".pend_valid"}, {31'd0, bus.pend_valid}, {31'd0, m_pend.size() != 0});
`ifdef PC_ALIGN_CHECK_EN
        chk({tag, ".misalign_f"}, {31'd0, bus.misalign_f}, {31'd0, m_mis});
`endif
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic rv,
                        input logic [31:0] t, input logic x);
        rst                = r;
        bus.en             = e;
        bus.redir_d_valid  = rv;
        bus.redir_d_target = t;
        bus.exc_valid      = x;
        model_edge(r, e, rv, t, x);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [31:0] rt;
        m_pc  = 32'd0;
        m_mis = 1'b0;
        rst = 1'b1; bus.en = 1'b0; bus.redir_d_valid = 1'b0;
        bus.redir_d_target = 32'd0; bus.exc_valid = 1'b0;

        // reset and sequential run
        step("reset", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("reset_pc", bus.pc_f, 32'h0000_3000);
        chk("reset_step", bus.pc_step_f, 32'h0000_3004);
        step("seq1", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        step("seq2", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        step("seq3", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("seq_pc", bus.pc_f, 32'h0000_300C);

        // redirect during stall is buffered, applied when en returns
        step("reset2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step("s1", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        step("s2", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("at_3008", bus.pc_f, 32'h0000_3008);
        step("stall_redir", 1'b0, 1'b0, 1'b1, 32'h0000_3100, 1'b0);
        chk("hold_pc", bus.pc_f, 32'h0000_3008);
        chk("hold_pend", {31'd0, bus.pend_valid}, 32'd1);
        step("stall_a", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step("stall_b", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step("release", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("pend_applied", bus.pc_f, 32'h0000_3100);
        chk("pend_clear", {31'd0, bus.pend_valid}, 32'd0);

        // live redirect beats pending one
        step("stall_redir2", 1'b0, 1'b0, 1'b1, 32'h0000_3100, 1'b0);
        step("live_wins", 1'b0, 1'b1, 1'b1, 32'h0000_3200, 1'b0);
        chk("live_pc", bus.pc_f, 32'h0000_3200);
        step("after_live", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("after_live_pc", bus.pc_f, 32'h0000_3204);

        // exception discards pending redirect
        step("stall_redir3", 1'b0, 1'b0, 1'b1, 32'h0000_3100, 1'b0);
        step("exc", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("exc_pc", bus.pc_f, 32'h0000_4180);
        chk("exc_pend", {31'd0, bus.pend_valid}, 32'd0);
        step("exc_seq1", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("exc_seq1_pc", bus.pc_f, 32'h0000_4184);
        step("exc_seq2", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);

        // newest buffered redirect wins
        step("nw1", 1'b0, 1'b0, 1'b1, 32'h0000_5000, 1'b0);
        step("nw2", 1'b0, 1'b0, 1'b1, 32'h0000_6000, 1'b0);
        step("nw_rel", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("newest_pc", bus.pc_f, 32'h0000_6000);

        // reset while holding
        step("stall_redir4", 1'b0, 1'b0, 1'b1, 32'h0000_3100, 1'b0);
        step("rst_hold", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("rst_hold_pc", bus.pc_f, 32'h0000_3000);
        chk("rst_hold_pend", {31'd0, bus.pend_valid}, 32'd0);

        // address wrap
        step("wrap_redir", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_step", bus.pc_step_f, 32'h0000_0000);
        step("wrap", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("wrap_pc", bus.pc_f, 32'h0000_0000);

        // misaligned redirect target
        step("mis_redir", 1'b0, 1'b1, 1'b1, 32'h0000_3102, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_pc", bus.pc_f, 32'h0000_4180);
        chk("mis_flag", {31'd0, bus.misalign_f}, 32'd1);
        step("mis_after", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("mis_flag_clr", {31'd0, bus.misalign_f}, 32'd0);
        step("mis_pend", 1'b0, 1'b0, 1'b1, 32'h0000_3201, 1'b0);
        step("mis_pend_rel", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("mis_pend_pc", bus.pc_f, 32'h0000_4180);
`else
        chk("mis_pc", bus.pc_f, 32'h0000_3102);
        step("mis_after", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("mis_after_pc", bus.pc_f, 32'h0000_3106);
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rt = $urandom;
            if ($urandom_range(0, 4) != 0) rt[1:0] = 2'b00;
            step("rand",
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0),
                 rt,
                 ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
